// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: control FSM that walks an AES datapath through
// INIT (AddRoundKey only), Nr-1 full rounds and a FINAL round without
// (Inv)MixColumns. It also issues the round-key index for either direction.
// Optional feature: define AES_ROUND_SEQ_STEP_EN to add a 'step' input.
// With that input present, INIT, ROUND and FINAL advance only on cycles where
// step is high.
// Each output is registered from the next-state decode, so it lines up with
// the state register during the same cycle.
module aes_round_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic       decrypt,
    input  logic       abort,
`ifdef AES_ROUND_SEQ_STEP_EN
    input  logic       step,
`endif
    output logic       busy,
    output logic       done,
    output logic       err_mode,
    output logic [3:0] round_idx,
    output logic [3:0] key_idx,
    output logic       load_state,
    output logic       add_key_only,
    output logic       skip_mix,
    output logic       capture
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        ROUND = 3'd2,
        FINAL = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] mode_q, mode_d;
    logic       dec_q, dec_d;
    logic       err_d;
    logic       advance;
    logic [3:0] nr_q, nr_d;

    logic       busy_d;
    logic [3:0] round_d;
    logic [3:0] key_d;

    // Number of rounds for a key-size code; code 11 never reaches the latch
    function automatic logic [3:0] nr_of(input logic [1:0] m);
        case (m)
            2'b00:   nr_of = 4'd10;
            2'b01:   nr_of = 4'd12;
            2'b10:   nr_of = 4'd14;
            default: nr_of = 4'd0;
        endcase
    endfunction

    // Round-advance qualifier: every cycle, or only on step pulses
    always_comb begin
`ifdef AES_ROUND_SEQ_STEP_EN
        advance = step;
`else
        advance = 1'b1;
`endif
    end

    // Nr follows the latched key size
    always_comb begin
        nr_q = nr_of(mode_q);
        nr_d = nr_of(mode_d);
    end

    // State, operation-parameter and round-counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= '0;
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            dec_q   <= dec_d;
        end
    end

    // Next-state, counter and latch logic; abort wins over every advance
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        dec_d   = dec_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (mode == 2'b11) begin
                        err_d = 1'b1;
                    end else begin
                        mode_d  = mode;
                        dec_d   = decrypt;
                        cnt_d   = '0;
                        state_d = INIT;
                    end
                end
            end
            INIT: begin
                if (abort) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (advance) begin
                    cnt_d   = 4'd1;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                if (abort) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (advance) begin
                    // Once the last full round is reached, jump straight to
                    // Nr. This keeps the counter bounded by the latched
                    // key size.
                    if ((cnt_q >= nr_q - 4'd1) || (cnt_q >= 4'd13)) begin
                        cnt_d   = nr_q;
                        state_d = FINAL;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            FINAL: begin
                if (abort) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (advance) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Output decode of the upcoming state and counter
    always_comb begin
        busy_d  = (state_d == INIT) || (state_d == ROUND) || (state_d == FINAL);
        round_d = busy_d ? cnt_d : '0;
        key_d   = '0;
        if (busy_d) begin
            key_d = dec_d ? (nr_d - cnt_d) : cnt_d;
        end
    end

    // Registered outputs, all cleared while reset is held
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            err_mode     <= 1'b0;
            round_idx    <= '0;
            key_idx      <= '0;
            load_state   <= 1'b0;
            add_key_only <= 1'b0;
            skip_mix     <= 1'b0;
            capture      <= 1'b0;
        end else begin
            busy         <= busy_d;
            done         <= (state_d == DONE);
            err_mode     <= err_d;
            round_idx    <= round_d;
            key_idx      <= key_d;
            load_state   <= (state_d == INIT);
            add_key_only <= (state_d == INIT);
            skip_mix     <= (state_d == FINAL);
            capture      <= (state_d == FINAL);
        end
    end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Testbench for aes_round_sequencer.
// A table of per-cycle stimulus and expected outputs drives the main checks.
// Hand-written sequences cover back-to-back operation and mid-run reset.
module tb_aes_round_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic [1:0] mode;
    logic       decrypt;
    logic       abort;
    logic       busy, done, err_mode;
    logic [3:0] round_idx, key_idx;
    logic       load_state, add_key_only, skip_mix, capture;

    int unsigned n_checks;
    int unsigned n_fails;

    aes_round_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .mode         (mode),
        .decrypt      (decrypt),
        .abort        (abort),
        .busy         (busy),
        .done         (done),
        .err_mode     (err_mode),
        .round_idx    (round_idx),
        .key_idx      (key_idx),
        .load_state   (load_state),
        .add_key_only (add_key_only),
        .skip_mix     (skip_mix),
        .capture      (capture)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: {busy,done,err,round[3:0],key[3:0],load,addkey,skip,capture}
    logic [14:0] obs;
    assign obs = {busy, done, err_mode, round_idx, key_idx,
                  load_state, add_key_only, skip_mix, capture};

    typedef struct {
        logic        start;
        logic [1:0]  mode;
        logic        dec;
        logic        abort;
        logic [14:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [14:0] mk(input logic b, input logic d, input logic e,
                                       input logic [3:0] ri, input logic [3:0] ki,
                                       input logic ld, input logic ak,
                                       input logic sk, input logic cp);
        mk = {b, d, e, ri, ki, ld, ak, sk, cp};
    endfunction

    function automatic logic [14:0] e_idle();
        e_idle = '0;
    endfunction
    function automatic logic [14:0] e_init(input logic [3:0] ki);
        e_init = mk(1'b1, 1'b0, 1'b0, 4'd0, ki, 1'b1, 1'b1, 1'b0, 1'b0);
    endfunction
    function automatic logic [14:0] e_round(input logic [3:0] ri, input logic [3:0] ki);
        e_round = mk(1'b1, 1'b0, 1'b0, ri, ki, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic logic [14:0] e_final(input logic [3:0] ri, input logic [3:0] ki);
        e_final = mk(1'b1, 1'b0, 1'b0, ri, ki, 1'b0, 1'b0, 1'b1, 1'b1);
    endfunction
    function automatic logic [14:0] e_done();
        e_done = mk(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic logic [14:0] e_err();
        e_err = mk(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic add(input logic s, input logic [1:0] m, input logic d,
                       input logic a, input logic [14:0] e);
        vec_t v;
        v.start = s; v.mode = m; v.dec = d; v.abort = a; v.exp = e;
        vecs.push_back(v);
    endtask

    // Start an operation and add entries for it up to and including FINAL.
    // While the run is busy, start, mode and decrypt are driven to different
    // values; none of them should change the result.
    task automatic add_run(input logic [1:0] m, input logic d, input int unsigned nr);
        logic [3:0] nr4;
        nr4 = 4'(nr);
        add(1'b1, m, d, 1'b0, e_init(d ? nr4 : 4'd0));
        for (int unsigned r = 1; r < nr; r++) begin
            add(r[0], ~m, ~d, 1'b0, e_round(4'(r), d ? nr4 - 4'(r) : 4'(r)));
        end
        add(1'b1, 2'b11, ~d, 1'b0, e_final(nr4, d ? 4'd0 : nr4));
    endtask

    task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %b required %b (busy,done,err,round,key,ld,ak,skip,cap)",
                     name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bound on total run time so a stuck bench still terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1);
    end

    initial begin
        int unsigned done_seen;
        n_checks = 0;
        n_fails  = 0;
        reset    = 1'b0;
        start    = 1'b0;
        mode     = 2'b00;
        decrypt  = 1'b0;
        abort    = 1'b0;

        // Table construction
        add_run(2'b00, 1'b0, 10);                        // encrypt 128
        add(1'b1, 2'b00, 1'b0, 1'b0, e_done());          // start ignored in FINAL
        add(1'b1, 2'b00, 1'b0, 1'b0, e_idle());          // start ignored in DONE
        add(1'b1, 2'b11, 1'b0, 1'b0, e_err());           // illegal mode
        add(1'b0, 2'b00, 1'b0, 1'b0, e_idle());
        add_run(2'b10, 1'b1, 14);                        // decrypt 256
        add(1'b0, 2'b00, 1'b0, 1'b0, e_done());
        add(1'b0, 2'b00, 1'b0, 1'b0, e_idle());
        add(1'b1, 2'b01, 1'b0, 1'b0, e_init(4'd0));      // 192, abort at round 5
        for (int unsigned r = 1; r <= 5; r++) begin
            add(1'b0, 2'b01, 1'b0, 1'b0, e_round(4'(r), 4'(r)));
        end
        add(1'b0, 2'b01, 1'b0, 1'b1, e_idle());
        add(1'b1, 2'b01, 1'b1, 1'b0, e_init(4'd12));     // new start accepted
        add(1'b0, 2'b01, 1'b1, 1'b1, e_idle());          // abort in INIT
        add(1'b0, 2'b00, 1'b0, 1'b1, e_idle());          // abort in IDLE: no effect
        add_run(2'b00, 1'b0, 10);
        add(1'b0, 2'b00, 1'b0, 1'b1, e_idle());          // abort beats FINAL->DONE
        add_run(2'b01, 1'b0, 12);
        add(1'b0, 2'b00, 1'b0, 1'b0, e_done());
        add(1'b0, 2'b00, 1'b0, 1'b1, e_idle());          // abort in DONE: no effect

        // Reset state
        repeat (2) tick();
        check("reset_outputs", obs, e_idle());
        reset = 1'b1;

        // Table-driven vectors; the first start falls on the first edge after release
        for (int unsigned i = 0; i < vecs.size(); i++) begin
            start   = vecs[i].start;
            mode    = vecs[i].mode;
            decrypt = vecs[i].dec;
            abort   = vecs[i].abort;
            tick();
            check($sformatf("vec%0d", i), obs, vecs[i].exp);
        end
        start = 1'b0;
        abort = 1'b0;
        tick();

        // Held start: done expected in cycles 12, 25 and 38
        start     = 1'b1;
        mode      = 2'b00;
        decrypt   = 1'b0;
        done_seen = 0;
        for (int unsigned c = 1; c <= 40; c++) begin
            tick();
            if (done) done_seen++;
            n_checks++;
            if (done !== ((c == 12) || (c == 25) || (c == 38))) begin
                n_fails++;
                $display("FAIL held_done_c%0d: got done=%b required %b", c, done,
                         (c == 12) || (c == 25) || (c == 38));
            end
        end
        check("held_done_count", 15'(done_seen), 15'd3);
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("held_abort_idle", obs, e_idle());

        // Held start with reset asserted in cycle 30 (round 3 of the third op)
        start = 1'b1;
        for (int unsigned c = 1; c <= 30; c++) tick();
        check("pre_reset_round3", obs, e_round(4'd3, 4'd3));
        reset = 1'b0;
        #1;
        check("reset_immediate", obs, e_idle());
        tick();
        check("reset_held", obs, e_idle());
        #2;
        reset = 1'b1;
        tick();
        check("first_start_after_reset", obs, e_init(4'd0));
        start = 1'b0;
        tick();
        check("after_reset_round1", obs, e_round(4'd1, 4'd1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
